length_counter: RTL and testbench

// - Per-channel NES APU length counter. Sits downstream of the write-change detector.
// - That detector's oChange pulse, raised when a channel's length register is rewritten,

---
 rtl/length_counter_if.sv | 23 ++
 rtl/length_counter.sv | 140 ++++++++++++++
 tb/tb_length_counter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/length_counter_if.sv
// Length counter bus: channel controls in, registered count/status out.
interface length_counter_if #(
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 enable;
    logic                 halt;
    logic                 load;
    logic [4:0]           index;
    logic                 half_frame;
    logic [CNT_WIDTH-1:0] count;
    logic                 active;
    logic [1:0]           state;

    modport master (
        output enable, halt, load, index, half_frame,
        input  count, active, state
    );

    modport slave (
        input  enable, halt, load, index, half_frame,
        output count, active, state
    );
endinterface

// File: rtl/length_counter.sv
// Per-channel NES APU length counter.
// The count is loaded from a 5-bit index and decremented on each half-frame tick.
// The optional macro LENGTH_TABLE_EN selects the NES length ROM.
// When it is undefined, the load value is index + 1.
module length_counter #(
    parameter int unsigned CNT_WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    length_counter_if.slave  bus
);

    typedef enum logic [1:0] {
        StOff   = 2'd0,
        StIdle  = 2'd1,
        StCount = 2'd2,
        StHold  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 active_q, active_d;
    logic [CNT_WIDTH-1:0] load_val;
    logic [CNT_WIDTH-1:0] dec_val;

`ifdef LENGTH_TABLE_EN
    logic [7:0] table_val;

    // NES length table lookup
    always_comb begin
        table_val = 8'd0;
        case (bus.index)
            5'd0:  table_val = 8'd10;
            5'd1:  table_val = 8'd254;
            5'd2:  table_val = 8'd20;
            5'd3:  table_val = 8'd2;
            5'd4:  table_val = 8'd40;
            5'd5:  table_val = 8'd4;
            5'd6:  table_val = 8'd80;
            5'd7:  table_val = 8'd6;
            5'd8:  table_val = 8'd160;
            5'd9:  table_val = 8'd8;
            5'd10: table_val = 8'd60;
            5'd11: table_val = 8'd10;
            5'd12: table_val = 8'd14;
            5'd13: table_val = 8'd12;
            5'd14: table_val = 8'd26;
            5'd15: table_val = 8'd14;
            5'd16: table_val = 8'd12;
            5'd17: table_val = 8'd16;
            5'd18: table_val = 8'd24;
            5'd19: table_val = 8'd18;
            5'd20: table_val = 8'd48;
            5'd21: table_val = 8'd20;
            5'd22: table_val = 8'd96;
            5'd23: table_val = 8'd22;
            5'd24: table_val = 8'd192;
            5'd25: table_val = 8'd24;
            5'd26: table_val = 8'd72;
            5'd27: table_val = 8'd26;
            5'd28: table_val = 8'd16;
            5'd29: table_val = 8'd28;
            5'd30: table_val = 8'd32;
            5'd31: table_val = 8'd30;
            default: table_val = 8'd10;
        endcase
        load_val = CNT_WIDTH'(table_val);
    end
`else
    // Test-voice mode: linear load value, always nonzero
    always_comb begin
        load_val = CNT_WIDTH'(bus.index) + CNT_WIDTH'(1);
    end
`endif

    // Saturating decrement so a stray tick can never wrap to all-ones
    always_comb begin
        dec_val = (count_q == '0) ? '0 : count_q - CNT_WIDTH'(1);
    end

    // Next-state: disable > load > decrement > halt change
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (!bus.enable) begin
            state_d = StOff;
            count_d = '0;
        end else begin
            case (state_q)
                StOff: begin
                    // Load is ignored on the enabling cycle
                    state_d = StIdle;
                    count_d = '0;
                end
                StIdle, StCount, StHold: begin
                    if (bus.load) begin
                        count_d = load_val;
                        state_d = bus.halt ? StHold : StCount;
                    end else if (state_q == StCount) begin
                        if (bus.half_frame) begin
                            count_d = dec_val;
                        end
                        if (bus.half_frame && dec_val == '0) begin
                            state_d = StIdle;
                        end else if (bus.halt) begin
                            state_d = StHold;
                        end
                    end else if (state_q == StHold) begin
                        if (!bus.halt) begin
                            state_d = StCount;
                        end
                    end
                end
                default: begin
                    state_d = StOff;
                    count_d = '0;
                end
            endcase
        end
        active_d = (count_d != '0);
    end

    // State, count and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StOff;
            count_q  <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            active_q <= active_d;
        end
    end

    assign bus.count  = count_q;
    assign bus.active = active_q;
    assign bus.state  = state_q;

endmodule

// File: tb/tb_length_counter.sv
// Directed testbench for length_counter; expected values follow LENGTH_TABLE_EN.
module tb_length_counter;

`ifdef LENGTH_TABLE_EN
    localparam int LV1  = 254;
    localparam int LV3  = 2;
    localparam int LV0  = 10;
    localparam int LV9  = 8;
    localparam int LV6  = 80;
    localparam int LV4  = 40;
    localparam int LV31 = 30;
`else
    localparam int LV1  = 2;
    localparam int LV3  = 4;
    localparam int LV0  = 1;
    localparam int LV9  = 10;
    localparam int LV6  = 7;
    localparam int LV4  = 5;
    localparam int LV31 = 32;
`endif

    localparam int OFF = 0, IDLE = 1, COUNT = 2, HOLD = 3;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    length_counter_if #(.CNT_WIDTH(8)) bus ();

    length_counter #(.CNT_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass         = 0;
        n_total        = 0;
        rst_n          = 1'b0;
        bus.enable     = 1'b0;
        bus.halt       = 1'b0;
        bus.load       = 1'b0;
        bus.index      = 5'd0;
        bus.half_frame = 1'b0;
        step();
        check("rst_count", int'(bus.count), 0);
        check("rst_active", int'(bus.active), 0);
        check("rst_state", int'(bus.state), OFF);

        // Load while disabled is ignored
        rst_n = 1'b1;
        step();
        bus.load  = 1'b1;
        bus.index = 5'd3;
        step();
        bus.load = 1'b0;
        check("dis_load_count", int'(bus.count), 0);
        check("dis_load_state", int'(bus.state), OFF);

        // Enable then load index 1
        bus.enable = 1'b1;
        step();
        check("en_idle", int'(bus.state), IDLE);
        bus.load  = 1'b1;
        bus.index = 5'd1;
        step();
        bus.load = 1'b0;
        check("load1_count", int'(bus.count), LV1);
        check("load1_active", int'(bus.active), 1);
        check("load1_state", int'(bus.state), COUNT);

        // Reload index 3 and count down to zero
        bus.load  = 1'b1;
        bus.index = 5'd3;
        step();
        bus.load = 1'b0;
        check("load3_count", int'(bus.count), LV3);
        for (int e = LV3 - 1; e >= 0; e--) begin
            bus.half_frame = 1'b1;
            step();
            bus.half_frame = 1'b0;
            check("countdown", int'(bus.count), e);
        end
        check("cd_active", int'(bus.active), 0);
        check("cd_state", int'(bus.state), IDLE);
        bus.half_frame = 1'b1;
        step();
        bus.half_frame = 1'b0;
        check("idle_tick_sat", int'(bus.count), 0);
        check("idle_tick_state", int'(bus.state), IDLE);

        // Halted load holds through ticks
        bus.halt  = 1'b1;
        bus.load  = 1'b1;
        bus.index = 5'd0;
        step();
        bus.load = 1'b0;
        check("hold_load_count", int'(bus.count), LV0);
        check("hold_state", int'(bus.state), HOLD);
        for (int i = 0; i < 5; i++) begin
            bus.half_frame = 1'b1;
            step();
        end
        bus.half_frame = 1'b0;
        check("hold_ticks_count", int'(bus.count), LV0);
        bus.halt = 1'b0;
        step();
        check("unhalt_state", int'(bus.state), COUNT);
        check("unhalt_count", int'(bus.count), LV0);

        // Load beats a simultaneous tick
        bus.half_frame = 1'b1;
        bus.load       = 1'b1;
        bus.index      = 5'd9;
        step();
        bus.half_frame = 1'b0;
        bus.load       = 1'b0;
        check("collide_count", int'(bus.count), LV9);
        check("collide_state", int'(bus.state), COUNT);

        // Disable mid-count
        bus.load  = 1'b1;
        bus.index = 5'd6;
        step();
        bus.load = 1'b0;
        check("load6_count", int'(bus.count), LV6);
        bus.enable = 1'b0;
        step();
        check("disable_count", int'(bus.count), 0);
        check("disable_active", int'(bus.active), 0);
        check("disable_state", int'(bus.state), OFF);
        bus.load  = 1'b1;
        bus.index = 5'd5;
        step();
        bus.load = 1'b0;
        check("off_load_count", int'(bus.count), 0);

        // Asynchronous reset mid-count
        bus.enable = 1'b1;
        step();
        bus.load  = 1'b1;
        bus.index = 5'd4;
        step();
        bus.load = 1'b0;
        check("load4_count", int'(bus.count), LV4);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", int'(bus.count), 0);
        check("async_rst_active", int'(bus.active), 0);
        check("async_rst_state", int'(bus.state), OFF);

        // Top index
        step();
        rst_n = 1'b1;
        step();
        step();
        check("reen_idle", int'(bus.state), IDLE);
        bus.load  = 1'b1;
        bus.index = 5'd31;
        step();
        bus.load = 1'b0;
        check("load31_count", int'(bus.count), LV31);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
